mem_stage_ls: RTL and testbench

- Next-generation MEM pipeline stage for the 5-stage CPU: EX→MEM pipeline register, width-parametrised load-data extraction (byte/half/word/dword, signed/unsigned), and a variable-latency data-SRAM handshake with wait FSM, early-data buffer and timeout.
- Drives the MEM→WB bus and the MEM→ID forwarding bus.
- Raises a stall request while a load is outstanding.

---
 rtl/mem_stage_ls_pkg.sv | 25 ++
 rtl/mem_stage_ls_if.sv | 47 ++++
 rtl/mem_stage_ls_load_extract.sv | 50 +++++
 rtl/mem_stage_ls.sv | 133 +++++++++++++
 tb/tb_mem_stage_ls.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ls_pkg.sv
// Shared constants for the MEM stage: load-op encodings, FSM states, fixed bus widths.
package mem_stage_ls_pkg;

    localparam logic [2:0] LDOP_LW  = 3'b000;
    localparam logic [2:0] LDOP_LB  = 3'b001;
    localparam logic [2:0] LDOP_LBU = 3'b010;
    localparam logic [2:0] LDOP_LH  = 3'b011;
    localparam logic [2:0] LDOP_LHU = 3'b100;
    localparam logic [2:0] LDOP_LD  = 3'b101;

    localparam int REG_W = 5;   // register-file address width
    localparam int PC_W  = 32;  // instruction address width
    localparam int CNT_W = 8;   // wait counter, holds WAIT_MAX up to 255

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Byte-offset bits needed to select a lane in a DW-bit word.
    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// EX->MEM slot, data-SRAM response, MEM->WB / forwarding buses and stall/hold controls.
interface mem_stage_ls_if #(
    parameter int DW        = 32,
    parameter int PAYLOAD_W = 67
);
    logic                 hold_i;
    logic                 bubble_i;
    logic                 in_valid;
    logic                 in_load;
    logic [2:0]           in_ldop;
    logic                 in_rf_we;
    logic [4:0]           in_rf_waddr;
    logic [DW-1:0]        in_ex_result;
    logic [31:0]          in_pc;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [DW-1:0]        dmem_rdata;
    logic                 dmem_data_ok;

    logic                 stallreq;
    logic                 out_valid;
    logic                 out_rf_we;
    logic [4:0]           out_rf_waddr;
    logic [DW-1:0]        out_rf_wdata;
    logic [31:0]          out_pc;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_adel;
    logic                 out_buserr;
    logic                 fwd_we;
    logic [4:0]           fwd_waddr;
    logic [DW-1:0]        fwd_wdata;

    // Pipeline/controller side: drives the slot and SRAM response, observes results.
    modport master (
        output hold_i, bubble_i, in_valid, in_load, in_ldop, in_rf_we, in_rf_waddr,
               in_ex_result, in_pc, in_payload, dmem_rdata, dmem_data_ok,
        input  stallreq, out_valid, out_rf_we, out_rf_waddr, out_rf_wdata, out_pc,
               out_payload, out_adel, out_buserr, fwd_we, fwd_waddr, fwd_wdata
    );

    // MEM stage side.
    modport slave (
        input  hold_i, bubble_i, in_valid, in_load, in_ldop, in_rf_we, in_rf_waddr,
               in_ex_result, in_pc, in_payload, dmem_rdata, dmem_data_ok,
        output stallreq, out_valid, out_rf_we, out_rf_waddr, out_rf_wdata, out_pc,
               out_payload, out_adel, out_buserr, fwd_we, fwd_waddr, fwd_wdata
    );
endinterface

// File: rtl/mem_stage_ls_load_extract.sv
// Combinational load-data extraction: lane select, sign/zero extension, alignment check.
module load_extract
    import mem_stage_ls_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW_LO = $clog2(DW / 8)
) (
    input  logic [2:0]       ldop,
    input  logic [AW_LO-1:0] lane,
    input  logic [DW-1:0]    rdata,
    output logic [DW-1:0]    wdata,
    output logic             misalign
);
    // Halfword/word lane bases ignore the low offset bits, so misaligned
    // accesses still read a well-defined (but discarded) value.
    logic [AW_LO-1:0] lane_h;
    logic [AW_LO-1:0] lane_w;

    assign lane_h = lane & ~AW_LO'(1);
    assign lane_w = lane & ~AW_LO'(3);

    // Pick the sized field and extend it; unknown encodings behave as LW.
    always_comb begin
        wdata    = DW'($signed(32'(rdata >> {lane_w, 3'b000})));
        misalign = |lane[1:0];
        case (ldop)
            LDOP_LB: begin
                wdata    = DW'($signed(8'(rdata >> {lane, 3'b000})));
                misalign = 1'b0;
            end
            LDOP_LBU: begin
                wdata    = DW'(8'(rdata >> {lane, 3'b000}));
                misalign = 1'b0;
            end
            LDOP_LH: begin
                wdata    = DW'($signed(16'(rdata >> {lane_h, 3'b000})));
                misalign = lane[0];
            end
            LDOP_LHU: begin
                wdata    = DW'(16'(rdata >> {lane_h, 3'b000}));
                misalign = lane[0];
            end
            LDOP_LD: begin
                wdata    = rdata;
                misalign = (DW != 64) || (lane != '0);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage_ls.sv
// MEM stage: EX->MEM register, load extraction, variable-latency SRAM wait with timeout.
module mem_stage_ls
    import mem_stage_ls_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW_LO     = $clog2(DW / 8),
    parameter int PAYLOAD_W = 67,
    parameter int WAIT_MAX  = 15
) (
    input logic         clk,
    input logic         rst,
    mem_stage_ls_if.slave bus
);
    typedef struct packed {
        logic                 valid;
        logic                 load;
        logic [2:0]           ldop;
        logic                 rf_we;
        logic [REG_W-1:0]     waddr;
        logic [DW-1:0]        ex;
        logic [PC_W-1:0]      pc;
        logic [PAYLOAD_W-1:0] payload;
    } slot_t;

    slot_t            slot;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             got;    // read data already captured in rbuf for this slot
    logic             berr;   // this slot already timed out (matters while held)
    logic [DW-1:0]    rbuf;

    logic          misalign, live, data_now, timeout, stall, keep, adel, buserr, valid, rf_we;
    logic [DW-1:0] ext_data;

    load_extract #(.DW(DW), .AW_LO(AW_LO)) u_extract (
        .ldop    (slot.ldop),
        .lane    (slot.ex[AW_LO-1:0]),
        .rdata   (got ? rbuf : bus.dmem_rdata),
        .wdata   (ext_data),
        .misalign(misalign)
    );

    // A live load is one the SRAM was actually asked for; misaligned loads never wait.
    assign live     = slot.valid & slot.load & ~misalign;
    assign data_now = got | bus.dmem_data_ok;
    assign timeout  = (state == ST_WAIT) & live & ~data_now & (cnt >= CNT_W'(WAIT_MAX));
    assign stall    = live & ~data_now & ~berr & ~timeout;
    // The register must also advance on the completing cycle, or the
    // instruction released from EX when stallreq drops would be lost.
    assign keep     = stall | bus.hold_i;
    assign adel     = slot.valid & slot.load & misalign;
    assign buserr   = live & ~got & (berr | timeout);
    assign valid    = slot.valid & ~stall;
    assign rf_we    = valid & slot.rf_we & ~adel & ~buserr;

    assign bus.stallreq     = stall;
    assign bus.out_valid    = valid;
    assign bus.out_rf_we    = rf_we;
    assign bus.out_rf_waddr = slot.waddr;
    assign bus.out_rf_wdata = slot.load ? ext_data : slot.ex;
    assign bus.out_pc       = slot.pc;
    assign bus.out_payload  = slot.payload;
    assign bus.out_adel     = adel;
    assign bus.out_buserr   = buserr;
    assign bus.fwd_we       = rf_we & valid;
    assign bus.fwd_waddr    = slot.waddr;
    assign bus.fwd_wdata    = bus.out_rf_wdata;

    // EX->MEM register: stall/hold keep, bubble clears, otherwise take the EX slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (!keep) begin
            if (bus.bubble_i) begin
                slot <= '0;
            end else begin
                slot.valid   <= bus.in_valid;
                slot.load    <= bus.in_load;
                slot.ldop    <= bus.in_ldop;
                slot.rf_we   <= bus.in_rf_we;
                slot.waddr   <= bus.in_rf_waddr;
                slot.ex      <= bus.in_ex_result;
                slot.pc      <= bus.in_pc;
                slot.payload <= bus.in_payload;
            end
        end
    end

    // Early-data buffer: remember a response (or a timeout) for a slot that stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            got  <= 1'b0;
            berr <= 1'b0;
            rbuf <= '0;
        end else if (!keep) begin
            got  <= 1'b0;
            berr <= 1'b0;
        end else begin
            if (live && bus.dmem_data_ok && !got && !berr) begin
                got  <= 1'b1;
                rbuf <= bus.dmem_rdata;
            end
            if (timeout) begin
                berr <= 1'b1;
            end
        end
    end

    // Wait FSM: counts cycles spent stalled on an outstanding load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stall) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                default: begin
                    if (stall) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls: a DW=32/WAIT_MAX=4 instance and a DW=64 instance.
module tb_mem_stage_ls;
    import mem_stage_ls_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_stage_ls_if #(.DW(32), .PAYLOAD_W(67)) b32();
    mem_stage_ls_if #(.DW(64), .PAYLOAD_W(67)) b64();

    mem_stage_ls #(.DW(32), .PAYLOAD_W(67), .WAIT_MAX(4)) dut32 (
        .clk(clk), .rst(rst), .bus(b32)
    );
    mem_stage_ls #(.DW(64), .PAYLOAD_W(67), .WAIT_MAX(15)) dut64 (
        .clk(clk), .rst(rst), .bus(b64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs sampled 2 time units later, well away from either edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic slot32(input logic v, input logic ld, input logic [2:0] op,
                          input logic [4:0] wa, input logic [31:0] ex, input logic [31:0] pc);
        b32.in_valid     = v;
        b32.in_load      = ld;
        b32.in_ldop      = op;
        b32.in_rf_we     = 1'b1;
        b32.in_rf_waddr  = wa;
        b32.in_ex_result = ex;
        b32.in_pc        = pc;
        b32.in_payload   = {3'b101, 32'hCAFE_0000, pc};
    endtask

    task automatic slot64(input logic v, input logic ld, input logic [2:0] op,
                          input logic [4:0] wa, input logic [63:0] ex);
        b64.in_valid     = v;
        b64.in_load      = ld;
        b64.in_ldop      = op;
        b64.in_rf_we     = 1'b1;
        b64.in_rf_waddr  = wa;
        b64.in_ex_result = ex;
        b64.in_pc        = 32'h0000_2000;
        b64.in_payload   = '0;
    endtask

    initial begin
        rst = 1'b1;
        b32.hold_i = 1'b0; b32.bubble_i = 1'b0; b32.dmem_data_ok = 1'b0; b32.dmem_rdata = '0;
        b64.hold_i = 1'b0; b64.bubble_i = 1'b0; b64.dmem_data_ok = 1'b0; b64.dmem_rdata = '0;
        slot32(1'b0, 1'b0, LDOP_LW, 5'd0, 32'h0, 32'h0);
        slot64(1'b0, 1'b0, LDOP_LW, 5'd0, 64'h0);
        cyc(); cyc();

        // Reset state; LB enters EX.
        rst = 1'b0;
        slot32(1'b1, 1'b1, LDOP_LB, 5'd5, 32'h1000_0003, 32'h0000_0100);
        #2;
        chk("rst_valid", b32.out_valid, 0);
        chk("rst_stall", b32.stallreq, 0);
        chk("rst_wdata", b32.out_rf_wdata, 0);
        chk("rst_fwd_we", b32.fwd_we, 0);
        chk("rst_pc", b32.out_pc, 0);

        // LB lane 3 with same-cycle data_ok: 0x80 sign-extended.
        cyc();
        b32.dmem_data_ok = 1'b1; b32.dmem_rdata = 32'h80FF_1234;
        slot32(1'b1, 1'b0, LDOP_LW, 5'd7, 32'hDEAD_BEEF, 32'h0000_0104);
        #2;
        chk("lb_stall", b32.stallreq, 0);
        chk("lb_valid", b32.out_valid, 1);
        chk("lb_wdata", b32.out_rf_wdata, 32'hFFFF_FF80);
        chk("lb_we", b32.out_rf_we, 1);
        chk("lb_fwd", {b32.fwd_we, b32.fwd_waddr, b32.fwd_wdata}, {1'b1, 5'd5, 32'hFFFF_FF80});
        chk("lb_pc", b32.out_pc, 32'h0000_0100);
        chk("lb_payload_hi", b32.out_payload[66:64], 3'b101);

        // ALU result passes straight through.
        cyc();
        b32.dmem_data_ok = 1'b0;
        slot32(1'b1, 1'b1, LDOP_LHU, 5'd9, 32'h2000_0002, 32'h0000_0108);
        #2;
        chk("alu_wdata", b32.out_rf_wdata, 32'hDEAD_BEEF);
        chk("alu_valid", b32.out_valid, 1);

        // LHU lane 2, data three cycles after the slot arrives.
        cyc();
        slot32(1'b0, 1'b0, LDOP_LW, 5'd0, 32'h0, 32'h0);
        #2;
        chk("lhu_stall0", {b32.stallreq, b32.out_valid}, 2'b10);
        cyc(); #2;
        chk("lhu_stall1", {b32.stallreq, b32.out_valid}, 2'b10);
        cyc(); #2;
        chk("lhu_stall2", {b32.stallreq, b32.out_valid}, 2'b10);
        cyc();
        b32.dmem_data_ok = 1'b1; b32.dmem_rdata = 32'hBEEF_0000;
        slot32(1'b1, 1'b1, LDOP_LW, 5'd3, 32'h3000_0001, 32'h0000_010C);
        #2;
        chk("lhu_done", {b32.stallreq, b32.out_valid, b32.out_rf_we}, 3'b011);
        chk("lhu_wdata", b32.out_rf_wdata, 32'h0000_BEEF);
        chk("lhu_waddr", b32.out_rf_waddr, 5'd9);

        // Misaligned LW: address error, no stall.
        cyc();
        b32.dmem_data_ok = 1'b0;
        slot32(1'b1, 1'b1, LDOP_LW, 5'd3, 32'h4000_0000, 32'h0000_0110);
        #2;
        chk("adel_flags", {b32.out_adel, b32.out_rf_we, b32.stallreq, b32.out_valid}, 4'b1001);
        chk("adel_fwd_we", b32.fwd_we, 0);

        // Timeout: four stalled cycles, then bus error.
        cyc();
        slot32(1'b0, 1'b0, LDOP_LW, 5'd0, 32'h0, 32'h0);
        #2;
        chk("to_stall0", b32.stallreq, 1);
        cyc(); #2; chk("to_stall1", b32.stallreq, 1);
        cyc(); #2; chk("to_stall2", b32.stallreq, 1);
        cyc(); #2; chk("to_stall3", {b32.stallreq, b32.out_buserr}, 2'b10);
        cyc();
        slot32(1'b1, 1'b1, LDOP_LW, 5'd4, 32'h5000_0000, 32'h0000_0114);
        #2;
        chk("to_err", {b32.stallreq, b32.out_valid, b32.out_buserr, b32.out_rf_we}, 4'b0110);

        // Next load stalls afresh (FSM back in IDLE); hold asserted.
        cyc();
        slot32(1'b0, 1'b0, LDOP_LW, 5'd0, 32'h0, 32'h0);
        b32.hold_i = 1'b1;
        #2;
        chk("hold_stall", {b32.stallreq, b32.out_buserr}, 2'b10);
        cyc();
        b32.dmem_data_ok = 1'b1; b32.dmem_rdata = 32'h1111_2222;
        #2;
        chk("hold_data", {b32.stallreq, b32.out_valid}, 2'b01);
        chk("hold_wdata0", b32.out_rf_wdata, 32'h1111_2222);
        cyc();
        b32.dmem_data_ok = 1'b0; b32.dmem_rdata = 32'hFFFF_FFFF;
        #2;
        chk("rbuf_wdata1", b32.out_rf_wdata, 32'h1111_2222);
        chk("rbuf_flags1", {b32.stallreq, b32.out_valid, b32.out_rf_we}, 3'b011);
        cyc();
        b32.hold_i = 1'b0; b32.bubble_i = 1'b1;
        #2;
        chk("rbuf_wdata2", b32.out_rf_wdata, 32'h1111_2222);
        chk("rbuf_stall2", b32.stallreq, 0);

        // Bubble loaded; a stray data_ok with no load latched is ignored.
        cyc();
        b32.bubble_i = 1'b0; b32.dmem_data_ok = 1'b1; b32.dmem_rdata = 32'h0000_ABCD;
        slot32(1'b1, 1'b1, LDOP_LW, 5'd6, 32'h6000_0000, 32'h0000_0118);
        #2;
        chk("bubble", {b32.out_valid, b32.fwd_we, b32.out_rf_we, b32.stallreq}, 4'b0000);

        // Reset in the middle of a wait; the late response is ignored.
        cyc();
        b32.dmem_data_ok = 1'b0;
        slot32(1'b0, 1'b0, LDOP_LW, 5'd0, 32'h0, 32'h0);
        #2;
        chk("rw_stall0", b32.stallreq, 1);
        cyc();
        rst = 1'b1;
        #2;
        chk("rw_stall1", b32.stallreq, 1);
        cyc();
        rst = 1'b0; b32.dmem_data_ok = 1'b1;
        #2;
        chk("rw_late", {b32.out_valid, b32.stallreq}, 2'b00);
        cyc();
        b32.dmem_data_ok = 1'b0;
        #2;
        chk("rw_idle", {b32.out_valid, b32.stallreq}, 2'b00);

        // DW=64 instance.
        slot64(1'b1, 1'b1, LDOP_LW, 5'd1, 64'h0000_0000_7000_0004);
        cyc();
        b64.dmem_data_ok = 1'b1; b64.dmem_rdata = 64'h8000_0001_1234_5678;
        slot64(1'b1, 1'b1, LDOP_LD, 5'd2, 64'h0000_0000_7000_0008);
        #2;
        chk("w64_wdata", b64.out_rf_wdata, 64'hFFFF_FFFF_8000_0001);
        chk("w64_flags", {b64.out_valid, b64.stallreq, b64.out_rf_we}, 3'b101);
        cyc();
        b64.dmem_rdata = 64'h0123_4567_89AB_CDEF;
        slot64(1'b1, 1'b1, LDOP_LD, 5'd3, 64'h0000_0000_7000_000C);
        #2;
        chk("ld64_wdata", b64.out_rf_wdata, 64'h0123_4567_89AB_CDEF);
        cyc();
        b64.dmem_data_ok = 1'b0;
        slot64(1'b1, 1'b1, LDOP_LBU, 5'd4, 64'h0000_0000_7000_0007);
        #2;
        chk("ld64_adel", {b64.out_adel, b64.out_rf_we, b64.stallreq}, 3'b100);
        cyc();
        b64.dmem_data_ok = 1'b1; b64.dmem_rdata = 64'hA500_0000_0000_0000;
        slot64(1'b1, 1'b1, LDOP_LH, 5'd5, 64'h0000_0000_7000_0006);
        #2;
        chk("lbu64_wdata", b64.out_rf_wdata, 64'h0000_0000_0000_00A5);
        cyc();
        b64.dmem_rdata = 64'h8001_0000_0000_0000;
        slot64(1'b0, 1'b0, LDOP_LW, 5'd0, 64'h0);
        #2;
        chk("lh64_wdata", b64.out_rf_wdata, 64'hFFFF_FFFF_FFFF_8001);
        cyc();
        b64.dmem_data_ok = 1'b0;
        #2;
        chk("end64_valid", b64.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
